// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: shared FSM state encoding, lab golden tables and sweep helpers
package truth_table_sweeper_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;
  localparam logic [7:0] MAJ3 = 8'hE8;
  localparam logic [7:0] AND3 = 8'h80;
  localparam logic [7:0] XOR3 = 8'h96;
  function automatic int unsigned sweep_len(input int unsigned n);
    return 32'd1 << n;
  endfunction
endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: sweep control, DUT stimulus/response and result bus; master = controller+DUT side, slave = sweeper
interface truth_table_sweeper_if #(parameter int N_IN = 3);
  logic                 start;
  logic [N_IN-1:0]      dut_in;
  logic                 dut_out;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2**N_IN-1:0]   captured;
  logic [N_IN:0]        err_count;
  logic [N_IN-1:0]      first_err_idx;
  modport master (
    output start, dut_out,
    input  dut_in, busy, done, pass, captured, err_count, first_err_idx
  );
  modport slave (
    input  start, dut_out,
    output dut_in, busy, done, pass, captured, err_count, first_err_idx
  );
endinterface

// File: rtl/truth_table_sweeper_settle.sv
// sweep_settle_timer: counts SETTLE cycles per vector (clk, rst, clear, en in; sample_tick out, 1 cycle)
module sweep_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic sample_tick
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  logic [CW-1:0] cnt;
  assign sample_tick = en && cnt == CW'(SETTLE - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clear || sample_tick) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all N_IN-bit vectors into a DUT, captures its truth table and compares to EXPECTED (clk, rst, bus: slave side of truth_table_sweeper_if)
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                 N_IN     = 3,
  parameter int                 SETTLE   = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = (2**N_IN)'(MAJ3)
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);
  localparam logic [N_IN-1:0] LAST = N_IN'(sweep_len(N_IN) - 1);
  state_t          state;
  logic [N_IN-1:0] idx;
  logic            tick;
  logic            accept;
  logic            miss;
  logic [N_IN:0]   err_next;
  assign accept   = bus.start && state != S_APPLY;
  assign miss     = bus.dut_out != EXPECTED[idx];
  assign err_next = bus.err_count + (N_IN+1)'(miss);
  assign bus.dut_in = idx;
  sweep_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (accept),
    .en          (state == S_APPLY),
    .sample_tick (tick)
  );
  // the final sample and its mismatch land on the DONE-entry edge, so pass uses err_next
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      idx               <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.pass          <= 1'b0;
      bus.captured      <= '0;
      bus.err_count     <= '0;
      bus.first_err_idx <= '0;
    end else if (accept) begin
      state             <= S_APPLY;
      idx               <= '0;
      bus.busy          <= 1'b1;
      bus.done          <= 1'b0;
      bus.pass          <= 1'b0;
      bus.captured      <= '0;
      bus.err_count     <= '0;
      bus.first_err_idx <= '0;
    end else if (state == S_APPLY && tick) begin
      bus.captured[idx] <= bus.dut_out;
      bus.err_count     <= err_next;
      if (miss && bus.err_count == '0) bus.first_err_idx <= idx;
      if (idx == LAST) begin
        state    <= S_DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.pass <= err_next == '0;
      end else idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: random and directed sweeps of two sweepers (SETTLE=2 and SETTLE=1) against a behavioural model
module tb_truth_table_sweeper;
  import truth_table_sweeper_pkg::*;
  typedef struct packed {
    logic [2:0] din;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] cap;
    logic [3:0] ec;
    logic [2:0] fe;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start_v = 2'b00;
  logic [7:0] tbl [2];
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   act [2];
  int   e0 [2];
  logic [7:0] snap [2];
  obs_t got [2];
  always #5 clk = ~clk;
  truth_table_sweeper_if #(.N_IN(3)) bus_a ();
  truth_table_sweeper_if #(.N_IN(3)) bus_b ();
  truth_table_sweeper #(.N_IN(3), .SETTLE(2), .EXPECTED(MAJ3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(MAJ3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  assign bus_a.start   = start_v[0];
  assign bus_b.start   = start_v[1];
  assign bus_a.dut_out = tbl[0][bus_a.dut_in];
  assign bus_b.dut_out = tbl[1][bus_b.dut_in];
  always_comb begin
    got[0] = {bus_a.dut_in, bus_a.busy, bus_a.done, bus_a.pass, bus_a.captured, bus_a.err_count, bus_a.first_err_idx};
    got[1] = {bus_b.dut_in, bus_b.busy, bus_b.done, bus_b.pass, bus_b.captured, bus_b.err_count, bus_b.first_err_idx};
  end
  function automatic int st(input int i);
    return i == 0 ? 2 : 1;
  endfunction
  // expected outputs from edges elapsed since the accepting edge and the table in force then
  function automatic obs_t model(input int i);
    obs_t o;
    int c, n;
    logic [7:0] gold, m;
    o = '0;
    gold = MAJ3;
    m = '0;
    if (!act[i]) return o;
    c = cyc - e0[i];
    n = c / st(i);
    if (n > 8) n = 8;
    for (int k = 0; k < n; k++) begin
      o.cap[k] = snap[i][k];
      m[k] = snap[i][k] != gold[k];
    end
    for (int k = 0; k < 8; k++) o.ec += 4'(m[k]);
    for (int k = 7; k >= 0; k--) if (m[k]) o.fe = 3'(k);
    o.done = c >= 8 * st(i);
    o.busy = !o.done;
    o.pass = o.done && o.ec == 0;
    o.din  = o.done ? 3'd7 : 3'(c / st(i));
    return o;
  endfunction
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++)
      if (rst) act[i] = 1'b0;
      else if (start_v[i] && (!act[i] || cyc - 1 - e0[i] >= 8 * st(i))) begin
        act[i]  = 1'b1;
        e0[i]   = cyc;
        snap[i] = tbl[i];
      end
  end
  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", nm, g, e, $time);
    end
  endtask
  always @(negedge clk) begin
    obs_t e;
    string nm;
    if (chk_en)
      for (int i = 0; i < 2; i++) begin
        e = model(i);
        nm = i == 0 ? "a" : "b";
        chk({nm, ".din"},  32'(got[i].din),  32'(e.din));
        chk({nm, ".busy"}, 32'(got[i].busy), 32'(e.busy));
        chk({nm, ".done"}, 32'(got[i].done), 32'(e.done));
        chk({nm, ".pass"}, 32'(got[i].pass), 32'(e.pass));
        chk({nm, ".cap"},  32'(got[i].cap),  32'(e.cap));
        chk({nm, ".ec"},   32'(got[i].ec),   32'(e.ec));
        chk({nm, ".fe"},   32'(got[i].fe),   32'(e.fe));
      end
  end
  task automatic pulse(input int i);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask
  task automatic wait_done(input int i, input int want, input string nm);
    int n;
    n = 0;
    while (!got[i].done && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(want));
  endtask
  initial begin
    int n;
    tbl[0] = MAJ3;
    tbl[1] = ~MAJ3;
    repeat (2) @(negedge clk);
    chk("rst din", 32'(got[0].din), 0);
    chk("rst busy", 32'(got[0].busy), 0);
    chk("rst done", 32'(got[0].done), 0);
    chk("rst pass", 32'(got[0].pass), 0);
    chk("rst cap", 32'(got[0].cap), 0);
    chk("rst ec", 32'(got[0].ec), 0);
    chk("rst fe", 32'(got[0].fe), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    pulse(0);
    wait_done(0, 16, "maj");
    chk("maj cap", 32'(got[0].cap), 32'hE8);
    chk("maj pass", 32'(got[0].pass), 1);
    chk("maj ec", 32'(got[0].ec), 0);
    chk("maj fe", 32'(got[0].fe), 0);
    tbl[0] = AND3;
    pulse(0);
    wait_done(0, 16, "and");
    chk("and cap", 32'(got[0].cap), 32'h80);
    chk("and ec", 32'(got[0].ec), 3);
    chk("and fe", 32'(got[0].fe), 3);
    chk("and pass", 32'(got[0].pass), 0);
    tbl[0] = XOR3;
    pulse(0);
    repeat (4) @(negedge clk);
    pulse(0);
    wait_done(0, 11, "ignored start");
    pulse(0);
    chk("restart done", 32'(got[0].done), 0);
    chk("restart cap", 32'(got[0].cap), 0);
    chk("restart busy", 32'(got[0].busy), 1);
    wait_done(0, 16, "restart");
    tbl[0] = MAJ3;
    pulse(0);
    n = 0;
    while (got[0].din != 3'd4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach din4", 32'(got[0].din), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst din", 32'(got[0].din), 0);
    chk("midrst cap", 32'(got[0].cap), 0);
    chk("midrst busy", 32'(got[0].busy), 0);
    pulse(0);
    wait_done(0, 16, "after rst");
    chk("after rst pass", 32'(got[0].pass), 1);
    pulse(1);
    wait_done(1, 8, "inv");
    chk("inv cap", 32'(got[1].cap), 32'h17);
    chk("inv ec", 32'(got[1].ec), 8);
    chk("inv fe", 32'(got[1].fe), 0);
    chk("inv pass", 32'(got[1].pass), 0);
    repeat (600) begin
      for (int i = 0; i < 2; i++) begin
        if (!model(i).busy && $urandom_range(3) == 0) tbl[i] = 8'($urandom);
        start_v[i] = $urandom_range(5) == 0;
      end
      rst = $urandom_range(80) == 0;
      @(negedge clk);
    end
    rst = 1'b0;
    start_v = 2'b00;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
